id_stage_hs: RTL and testbench

- Parametrised decode stage with a valid/ready handshake on both sides. Generalises the earlier fixed 32-bit ID stage, which used global stall inputs.
- Sits between the IF/ID register and EX. Decodes RV32I instructions, drives register-file read addresses, and applies WB-to-ID bypass.
- Detects load-use hazards internally and inserts a bubble. Holds the ID/EX register under EX backpressure and honours a branch/jump flush.

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/rv_decoder.sv | 63 ++++++
 rtl/id_stage_hs.sv | 181 ++++++++++++++++++
 tb/tb_id_stage_hs.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, control-vector bit positions and ALU-op encodings.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int unsigned CTRL_W          = 9;
    localparam int unsigned CTRL_ALU_SRC    = 8;
    localparam int unsigned CTRL_ALU_OP_HI  = 7;
    localparam int unsigned CTRL_ALU_OP_LO  = 6;
    localparam int unsigned CTRL_BRANCH     = 5;
    localparam int unsigned CTRL_JUMP       = 4;
    localparam int unsigned CTRL_MEM_READ   = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_REG_WRITE  = 0;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_REG    = 2'b10;
    localparam logic [1:0] ALU_OP_IMM    = 2'b11;

endpackage

// File: rtl/rv_decoder.sv
// Opcode-only main decoder: control vector, illegal flag and source-register usage.
module rv_decoder
    import rv32_pkg::*;
(
    input  logic [6:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o,
    output logic              rs1_used_o,
    output logic              rs2_used_o
);

    always_comb begin
        ctrl_o     = '0;
        illegal_o  = 1'b0;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b0;
        case (opcode_i)
            OP_LUI, OP_AUIPC: begin
                ctrl_o[CTRL_ALU_SRC]   = 1'b1;
                ctrl_o[CTRL_REG_WRITE] = 1'b1;
                rs1_used_o             = 1'b0;
            end
            OP_JAL: begin
                ctrl_o[CTRL_JUMP]      = 1'b1;
                ctrl_o[CTRL_REG_WRITE] = 1'b1;
                rs1_used_o             = 1'b0;
            end
            OP_JALR: begin
                ctrl_o[CTRL_ALU_SRC]   = 1'b1;
                ctrl_o[CTRL_JUMP]      = 1'b1;
                ctrl_o[CTRL_REG_WRITE] = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_o[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_BRANCH;
                ctrl_o[CTRL_BRANCH]                   = 1'b1;
                rs2_used_o                            = 1'b1;
            end
            OP_LOAD: begin
                ctrl_o[CTRL_ALU_SRC]    = 1'b1;
                ctrl_o[CTRL_MEM_READ]   = 1'b1;
                ctrl_o[CTRL_MEM_TO_REG] = 1'b1;
                ctrl_o[CTRL_REG_WRITE]  = 1'b1;
            end
            OP_STORE: begin
                ctrl_o[CTRL_ALU_SRC]   = 1'b1;
                ctrl_o[CTRL_MEM_WRITE] = 1'b1;
                rs2_used_o             = 1'b1;
            end
            OP_IMM: begin
                ctrl_o[CTRL_ALU_SRC]                  = 1'b1;
                ctrl_o[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_IMM;
                ctrl_o[CTRL_REG_WRITE]                = 1'b1;
            end
            OP_REG: begin
                ctrl_o[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_OP_REG;
                ctrl_o[CTRL_REG_WRITE]                = 1'b1;
                rs2_used_o                            = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_hs.sv
// RV32I decode stage with valid/ready handshake, WB bypass, load-use bubble and flush.
module id_stage_hs
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter bit          CLEAR_ON_BUBBLE = 1'b1,
    parameter bit          HAZARD_EN       = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rs1_data,
    output logic [XLEN-1:0]   id_rs2_data,
    output logic [XLEN-1:0]   id_imm,
    output logic [4:0]        id_rs1,
    output logic [4:0]        id_rs2,
    output logic [4:0]        id_rd,
    output logic [2:0]        id_funct3,
    output logic [6:0]        id_funct7,
    output logic [CTRL_W-1:0] id_ctrl,
    output logic              id_illegal,
    output logic              load_use_stall
);

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    assign opcode    = if_instr[6:0];
    assign rs1       = if_instr[19:15];
    assign rs2       = if_instr[24:20];
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal, rs1_used, rs2_used;

    rv_decoder u_decoder (
        .opcode_i   (opcode),
        .ctrl_o     (dec_ctrl),
        .illegal_o  (dec_illegal),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used)
    );

    // Built as a signed 32-bit value so the cast to XLEN sign-extends.
    logic signed [31:0] imm32;
    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_JALR, OP_LOAD, OP_IMM: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:  imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH: imm32 = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                                if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {if_instr[31:12], 12'b0};
            OP_JAL:    imm32 = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                                if_instr[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
    end

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    assign rs1_fwd = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_rdata1;
    assign rs2_fwd = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_rdata2;

    logic              valid_q, valid_d, illegal_q, illegal_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic advance, hazard, bubble;
    assign advance = !valid_q || ex_ready;
    assign hazard  = HAZARD_EN && if_valid && valid_q && ctrl_q[CTRL_MEM_READ] && rd_q != 5'd0
                     && ((rd_q == rs1 && rs1_used) || (rd_q == rs2 && rs2_used));
    assign load_use_stall = hazard && !flush;
    assign if_ready       = flush || (advance && !hazard);
    // Flush beats backpressure; an idle advance is treated like a bubble.
    assign bubble = flush || (advance && (hazard || !if_valid));

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_ON_BUBBLE) begin
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                funct3_d   = '0;
                funct7_d   = '0;
                illegal_d  = 1'b0;
            end
        end else if (advance) begin
            valid_d    = 1'b1;
            pc_d       = if_pc;
            rs1_data_d = rs1_fwd;
            rs2_data_d = rs2_fwd;
            imm_d      = XLEN'(imm32);
            rs1_d      = rs1;
            rs2_d      = rs2;
            rd_d       = if_instr[11:7];
            funct3_d   = if_instr[14:12];
            funct7_d   = if_instr[31:25];
            ctrl_d     = dec_ctrl;
            illegal_d  = dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_pc       = pc_q;
    assign id_rs1_data = rs1_data_q;
    assign id_rs2_data = rs2_data_q;
    assign id_imm      = imm_q;
    assign id_rs1      = rs1_q;
    assign id_rs2      = rs2_q;
    assign id_rd       = rd_q;
    assign id_funct3   = funct3_q;
    assign id_funct7   = funct7_q;
    assign id_ctrl     = ctrl_q;
    assign id_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed and random checks of id_stage_hs against an instruction-level reference model.
module tb_id_stage_hs;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33;

    logic        clk = 1'b0;
    logic        reset_n, if_valid, flush, wb_we, ex_ready;
    logic [31:0] if_pc, if_instr, rf_rdata1, rf_rdata2, wb_data;
    logic [4:0]  wb_rd;
    logic        if_ready, id_valid, id_illegal, load_use_stall;
    logic [4:0]  rf_raddr1, rf_raddr2, id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [8:0]  id_ctrl;

    always #5 clk = ~clk;

    id_stage_hs #(.XLEN(32), .CLEAR_ON_BUBBLE(1'b1), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_ready(ex_ready), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .id_ctrl(id_ctrl), .id_illegal(id_illegal),
        .load_use_stall(load_use_stall)
    );

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [8:0]  ctrl;
        logic        illegal;
    } st_t;

    st_t m;
    int  checks = 0;
    int  failures = 0;
    logic [6:0] ops [10] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, 7'h7F};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] src(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OPR || op == ST || op == BR;
    endfunction

    // Instruction-level view: what EX should see for the instruction now at IF/ID.
    function automatic st_t decode(input logic [31:0] ins);
        st_t s;
        logic [6:0] op;
        op = ins[6:0];
        s = '0;
        s.valid = 1'b1;
        s.pc = if_pc;
        s.rs1 = ins[19:15];
        s.rs2 = ins[24:20];
        s.rd = ins[11:7];
        s.f3 = ins[14:12];
        s.f7 = ins[31:25];
        s.rs1d = src(s.rs1, rf_rdata1);
        s.rs2d = src(s.rs2, rf_rdata2);
        case (op)
            LUI, AUIPC: begin s.ctrl = 9'b1_00_000001; s.imm = ins & 32'hFFFF_F000; end
            JAL: begin
                s.ctrl = 9'b0_00_010001;
                s.imm = 32'(ins[30:21]) * 32'd2 + 32'(ins[20]) * 32'd2048
                        + 32'(ins[19:12]) * 32'd4096 - (ins[31] ? 32'd1048576 : 32'd0);
            end
            JALR, LD, OPI: begin
                s.ctrl = (op == JALR) ? 9'b1_00_010001 : (op == LD) ? 9'b1_00_001011
                                                                    : 9'b1_11_000001;
                s.is_load = (op == LD);
                s.imm = 32'(ins[30:20]) - (ins[31] ? 32'd2048 : 32'd0);
            end
            ST: begin
                s.ctrl = 9'b1_00_000100;
                s.imm = 32'(ins[30:25]) * 32'd32 + 32'(ins[11:7]) - (ins[31] ? 32'd2048 : 32'd0);
            end
            BR: begin
                s.ctrl = 9'b0_01_100000;
                s.imm = 32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2
                        + 32'(ins[7]) * 32'd2048 - (ins[31] ? 32'd4096 : 32'd0);
            end
            OPR: s.ctrl = 9'b0_10_000001;
            default: s.illegal = 1'b1;
        endcase
        return s;
    endfunction

    task automatic check_state();
        chk("id_valid", id_valid, m.valid);
        chk("id_ctrl", id_ctrl, m.ctrl);
        if (m.valid) begin
            chk("id_pc", id_pc, m.pc);
            chk("id_rs1_data", id_rs1_data, m.rs1d);
            chk("id_rs2_data", id_rs2_data, m.rs2d);
            chk("id_imm", id_imm, m.imm);
            chk("id_rs1", id_rs1, m.rs1);
            chk("id_rs2", id_rs2, m.rs2);
            chk("id_rd", id_rd, m.rd);
            chk("id_funct3", id_funct3, m.f3);
            chk("id_funct7", id_funct7, m.f7);
            chk("id_illegal", id_illegal, m.illegal);
        end
    endtask

    // Called just after an active edge with inputs already applied.
    task automatic cycle();
        logic adv, hz;
        st_t  nx;
        adv = !m.valid || ex_ready;
        hz = if_valid && m.valid && m.is_load && m.rd != 5'd0
             && ((m.rd == if_instr[19:15] && uses_rs1(if_instr[6:0]))
              || (m.rd == if_instr[24:20] && uses_rs2(if_instr[6:0])));
        #1;
        chk("if_ready", if_ready, flush || (adv && !hz));
        chk("load_use_stall", load_use_stall, hz && !flush);
        chk("rf_raddr1", rf_raddr1, if_instr[19:15]);
        chk("rf_raddr2", rf_raddr2, if_instr[24:20]);
        if (flush || (adv && (hz || !if_valid))) nx = '0;
        else if (adv) nx = decode(if_instr);
        else nx = m;
        @(posedge clk);
        m = nx;
        #1;
        check_state();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic er, input logic fl);
        if_valid = v;
        if_instr = ins;
        if_pc = pc;
        ex_ready = er;
        flush = fl;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
        m = '0;
        #12;
        chk("reset_valid", id_valid, 1'b0);
        chk("reset_ctrl", id_ctrl, 9'd0);
        chk("reset_illegal", id_illegal, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x1,x0,5
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        cycle();
        chk("addi_imm", id_imm, 32'd5);
        chk("addi_rd", id_rd, 5'd1);
        chk("addi_regwrite_alusrc", {id_ctrl[8], id_ctrl[0]}, 2'b11);

        // LW x2,0(x1) then dependent ADD x3,x2,x4
        drive(1'b1, 32'h0000_A103, 32'h104, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h0041_01B3, 32'h108, 1'b1, 1'b0);
        #1;
        chk("lu_stall", load_use_stall, 1'b1);
        chk("lu_ready", if_ready, 1'b0);
        cycle();
        chk("lu_bubble", id_valid, 1'b0);
        cycle();
        chk("lu_issue_rd", id_rd, 5'd3);

        // EX backpressure for three cycles on ADD, then accept ADDI x7,x3,1
        drive(1'b1, 32'h0011_8393, 32'h10C, 1'b0, 1'b0);
        repeat (3) begin
            cycle();
            chk("bp_pc_held", id_pc, 32'h108);
        end
        ex_ready = 1'b1;
        cycle();
        chk("bp_release_rd", id_rd, 5'd7);

        // Flush wins over a load-use hazard under backpressure
        drive(1'b1, 32'h0000_A103, 32'h110, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h0041_01B3, 32'h114, 1'b0, 1'b1);
        #1;
        chk("flush_ready", if_ready, 1'b1);
        chk("flush_stall", load_use_stall, 1'b0);
        cycle();
        chk("flush_valid", id_valid, 1'b0);

        // WB bypass, and x0 never bypassed
        drive(1'b1, 32'h0002_8333, 32'h200, 1'b1, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; rf_rdata1 = 32'd0;
        cycle();
        chk("bypass_rs1", id_rs1_data, 32'hDEAD_BEEF);
        drive(1'b1, 32'h0000_0333, 32'h204, 1'b1, 1'b0);
        wb_rd = 5'd0; wb_data = 32'h1234_5678; rf_rdata1 = 32'h55;
        cycle();
        chk("x0_rs1", id_rs1_data, 32'd0);
        wb_we = 1'b0;

        // Illegal opcode still issues, with no control bits
        drive(1'b1, 32'h0000_007F, 32'h208, 1'b1, 1'b0);
        cycle();
        chk("illegal_flag", id_illegal, 1'b1);
        chk("illegal_ctrl", id_ctrl, 9'd0);
        chk("illegal_valid", id_valid, 1'b1);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h0050_0093, 32'h20C, 1'b1, 1'b0);
        cycle();
        reset_n = 1'b0;
        #2;
        chk("areset_valid", id_valid, 1'b0);
        chk("areset_pc", id_pc, 32'd0);
        chk("areset_imm", id_imm, 32'd0);
        chk("areset_rd", id_rd, 5'd0);
        chk("areset_ctrl", id_ctrl, 9'd0);
        m = '0;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with small register indices to provoke hazards and bypasses
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0);
            wb_we = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
